// File: rtl/control_unit_if.sv
// Decoder-facing bundle: instruction fields in, control strobes and qualifiers out.
// Carries illegal_count only when CTRL_ILLEGAL_CNT_EN is defined.
interface control_unit_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  alu_op;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;
    logic        illegal_seen;
`ifdef CTRL_ILLEGAL_CNT_EN
    logic [15:0] illegal_count;
`endif

    // Fetch/datapath side: supplies the instruction fields, consumes the decode.
    modport master (
        output opcode, funct3,
        input  branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        input  alu_op, jal, jalr, lui, auipc, mem_size, mem_unsigned,
        input  illegal, illegal_seen
`ifdef CTRL_ILLEGAL_CNT_EN
        , input illegal_count
`endif
    );

    modport slave (
        input  opcode, funct3,
        output branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        output alu_op, jal, jalr, lui, auipc, mem_size, mem_unsigned,
        output illegal, illegal_seen
`ifdef CTRL_ILLEGAL_CNT_EN
        , output illegal_count
`endif
    );
endinterface

// File: rtl/control_unit.sv
// RV32I main decoder: opcode -> datapath strobes, funct3 -> memory qualifiers, sticky illegal flag.
// Optional saturating illegal-instruction counter enabled by CTRL_ILLEGAL_CNT_EN.
module control_unit (
    input  logic         clk,
    input  logic         rst,
    control_unit_if.slave ctrl
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       branch_d, mem_read_d, mem_to_reg_d, mem_write_d;
    logic       alu_src_d, reg_write_d, jal_d, jalr_d, lui_d, auipc_d;
    logic [1:0] alu_op_d;
    logic       op_known;
    logic [1:0] mem_size_d;
    logic       mem_unsigned_d;
    logic       funct3_bad;
    logic       illegal_d;
    logic       illegal_seen_q;

    // Strobes see opcode only, so an undriven funct3 can never pollute them.
    always_comb begin
        branch_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        alu_op_d     = 2'b00;
        jal_d        = 1'b0;
        jalr_d       = 1'b0;
        lui_d        = 1'b0;
        auipc_d      = 1'b0;
        op_known     = 1'b1;
        case (ctrl.opcode)
            OP_R: begin
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_I_ALU: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_LOAD: begin
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
                alu_src_d    = 1'b1;
                reg_write_d  = 1'b1;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
            end
            OP_BRANCH: begin
                branch_d = 1'b1;
                alu_op_d = 2'b01;
            end
            OP_JAL: begin
                reg_write_d = 1'b1;
                jal_d       = 1'b1;
            end
            OP_JALR: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                jalr_d      = 1'b1;
            end
            OP_LUI: begin
                reg_write_d = 1'b1;
                lui_d       = 1'b1;
            end
            OP_AUIPC: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                auipc_d     = 1'b1;
            end
            default: op_known = 1'b0;
        endcase
    end

    always_comb begin
        mem_size_d     = 2'b00;
        mem_unsigned_d = 1'b0;
        funct3_bad     = 1'b0;
        case (ctrl.opcode)
            OP_LOAD: begin
                mem_size_d     = ctrl.funct3[1:0];
                mem_unsigned_d = ctrl.funct3[2];
                funct3_bad     = (ctrl.funct3 == 3'b011) || (ctrl.funct3 == 3'b110) ||
                                 (ctrl.funct3 == 3'b111);
            end
            OP_STORE: begin
                mem_size_d = ctrl.funct3[1:0];
                funct3_bad = (ctrl.funct3 >= 3'b011);
            end
            OP_BRANCH: funct3_bad = (ctrl.funct3[2:1] == 2'b01);
            OP_JALR:   funct3_bad = (ctrl.funct3 != 3'b000);
            default:   funct3_bad = 1'b0;
        endcase
        illegal_d = !op_known || funct3_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen_q <= 1'b0;
        end else if (illegal_d) begin
            illegal_seen_q <= 1'b1;
        end
    end

`ifdef CTRL_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_q <= 16'h0000;
        end else if (illegal_d && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_q <= illegal_cnt_q + 16'h0001;
        end
    end

    assign ctrl.illegal_count = illegal_cnt_q;
`endif

    assign ctrl.branch       = branch_d;
    assign ctrl.mem_read     = mem_read_d;
    assign ctrl.mem_to_reg   = mem_to_reg_d;
    assign ctrl.mem_write    = mem_write_d;
    assign ctrl.alu_src      = alu_src_d;
    assign ctrl.reg_write    = reg_write_d;
    assign ctrl.alu_op       = alu_op_d;
    assign ctrl.jal          = jal_d;
    assign ctrl.jalr         = jalr_d;
    assign ctrl.lui          = lui_d;
    assign ctrl.auipc        = auipc_d;
    assign ctrl.mem_size     = mem_size_d;
    assign ctrl.mem_unsigned = mem_unsigned_d;
    assign ctrl.illegal      = illegal_d;
    assign ctrl.illegal_seen = illegal_seen_q;
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven decode model, randomized sweep,
// sticky-flag and asynchronous reset scenarios, counter scenario under CTRL_ILLEGAL_CNT_EN.
module tb_control_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    control_unit_if ctrl();

    control_unit dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rows: {br,mr,m2r,mw,asrc,regw,alu_op[1:0],jal,jalr,lui,auipc}
    logic [6:0]  ref_ops  [0:8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                    7'b0010111};
    logic [12:0] ref_rows [0:8] = '{13'b0_0_0_0_0_1_10_0_0_0_0,
                                    13'b0_0_0_0_1_1_10_0_0_0_0,
                                    13'b0_1_1_0_1_1_00_0_0_0_0,
                                    13'b0_0_0_1_1_0_00_0_0_0_0,
                                    13'b1_0_0_0_0_0_01_0_0_0_0,
                                    13'b0_0_0_0_0_1_00_1_0_0_0,
                                    13'b0_0_0_0_1_1_00_0_1_0_0,
                                    13'b0_0_0_0_0_1_00_0_0_1_0,
                                    13'b0_0_0_0_1_1_00_0_0_0_1};
    // Bit n set means funct3 == n is a legal encoding under that opcode.
    logic [7:0]  ref_f3ok [0:8] = '{8'hFF, 8'hFF, 8'b0011_0111, 8'b0000_0111,
                                    8'b1111_0011, 8'hFF, 8'b0000_0001, 8'hFF, 8'hFF};

    wire [12:0] obs_strobes = {ctrl.branch, ctrl.mem_read, ctrl.mem_to_reg, ctrl.mem_write,
                               ctrl.alu_src, ctrl.reg_write, ctrl.alu_op, ctrl.jal,
                               ctrl.jalr, ctrl.lui, ctrl.auipc};

    logic seen_model;

    task automatic model(input logic [6:0] op, input logic [2:0] f3,
                         output logic [12:0] strobes, output logic [1:0] size,
                         output logic uns, output logic ill);
        int idx;
        idx = -1;
        for (int k = 0; k < 9; k++) if (ref_ops[k] == op) idx = k;
        strobes = 13'd0;
        size    = 2'b00;
        uns     = 1'b0;
        ill     = 1'b1;
        if (idx >= 0) begin
            strobes = ref_rows[idx];
            ill     = !ref_f3ok[idx][f3];
            if (idx == 2 || idx == 3) size = f3[1:0];
            if (idx == 2) uns = f3[2];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen_model = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        ctrl.opcode = 7'b0000000;
        ctrl.funct3 = 3'b000;
        #1;
        checks++;
        if (ctrl.illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_seen: got %b want 0", ctrl.illegal_seen);
        end
        checks++;
        if (ctrl.illegal !== 1'b1) begin
            errors++;
            $display("FAIL reset_illegal_comb: got %b want 1", ctrl.illegal);
        end
        @(posedge clk); #1;
        checks++;
        if (ctrl.illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: got %b want 0", ctrl.illegal_seen);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_model = 1'b0;
    endtask

    task automatic test_opcode_table();
        logic [12:0] es; logic [1:0] sz; logic un; logic il;
        for (int k = 0; k < 9; k++) begin
            ctrl.opcode = ref_ops[k];
            ctrl.funct3 = 3'bxxx;
            #1;
            model(ref_ops[k], 3'b000, es, sz, un, il);
            checks++;
            if (obs_strobes !== es) begin
                errors++;
                $display("FAIL table_op_%b: got %b want %b", ref_ops[k], obs_strobes, es);
            end
        end
    endtask

    task automatic test_unknown_opcodes();
        logic [6:0] bad [0:3];
        bad = '{7'b0000000, 7'b1111111, 7'b1010101, 7'b0101010};
        for (int k = 0; k < 4; k++) begin
            ctrl.opcode = bad[k];
            ctrl.funct3 = 3'(k);
            #1;
            checks++;
            if (obs_strobes !== 13'd0 || ctrl.illegal !== 1'b1) begin
                errors++;
                $display("FAIL unknown_op_%b: strobes %b illegal %b want 0 / 1",
                         bad[k], obs_strobes, ctrl.illegal);
            end
        end
    endtask

    task automatic test_mem_qualifiers();
        ctrl.opcode = 7'b0000011; ctrl.funct3 = 3'b100; #1;
        checks++;
        if (ctrl.mem_size !== 2'b00 || ctrl.mem_unsigned !== 1'b1) begin
            errors++;
            $display("FAIL load_lbu: size %b uns %b want 00 1", ctrl.mem_size, ctrl.mem_unsigned);
        end
        ctrl.funct3 = 3'b001; #1;
        checks++;
        if (ctrl.mem_size !== 2'b01 || ctrl.mem_unsigned !== 1'b0) begin
            errors++;
            $display("FAIL load_lh: size %b uns %b want 01 0", ctrl.mem_size, ctrl.mem_unsigned);
        end
        ctrl.opcode = 7'b0100011; ctrl.funct3 = 3'b010; #1;
        checks++;
        if (ctrl.mem_size !== 2'b10 || ctrl.mem_unsigned !== 1'b0 || ctrl.illegal !== 1'b0) begin
            errors++;
            $display("FAIL store_sw: size %b uns %b ill %b want 10 0 0",
                     ctrl.mem_size, ctrl.mem_unsigned, ctrl.illegal);
        end
    endtask

    task automatic test_funct3_illegal();
        ctrl.opcode = 7'b1100111; ctrl.funct3 = 3'b001; #1;
        checks++;
        if (ctrl.jalr !== 1'b1 || ctrl.reg_write !== 1'b1 || ctrl.illegal !== 1'b1) begin
            errors++;
            $display("FAIL jalr_bad_f3: jalr %b regw %b ill %b want 1 1 1",
                     ctrl.jalr, ctrl.reg_write, ctrl.illegal);
        end
        ctrl.opcode = 7'b1100011; ctrl.funct3 = 3'b010; #1;
        checks++;
        if (ctrl.branch !== 1'b1 || ctrl.illegal !== 1'b1) begin
            errors++;
            $display("FAIL branch_bad_f3: br %b ill %b want 1 1", ctrl.branch, ctrl.illegal);
        end
        ctrl.opcode = 7'b0100011; ctrl.funct3 = 3'b011; #1;
        checks++;
        if (ctrl.mem_write !== 1'b1 || ctrl.illegal !== 1'b1) begin
            errors++;
            $display("FAIL store_bad_f3: mw %b ill %b want 1 1", ctrl.mem_write, ctrl.illegal);
        end
    endtask

    task automatic test_random();
        logic [12:0] es; logic [1:0] sz; logic un; logic il;
        logic [6:0] op; logic [2:0] f3;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) op = ref_ops[$urandom_range(0, 8)];
            else                           op = 7'($urandom);
            // Mostly legal traffic so the sticky flag is exercised late, not at once.
            if (n < 150 && $urandom_range(0, 15) != 0) f3 = 3'b000;
            else                                       f3 = 3'($urandom);
            if (n < 150 && $urandom_range(0, 15) != 0) op = ref_ops[$urandom_range(0, 8)];
            ctrl.opcode = op;
            ctrl.funct3 = f3;
            #1;
            model(op, f3, es, sz, un, il);
            checks++;
            if (obs_strobes !== es || ctrl.mem_size !== sz || ctrl.mem_unsigned !== un ||
                ctrl.illegal !== il) begin
                errors++;
                $display("FAIL rand_decode op=%b f3=%b: got %b/%b/%b/%b want %b/%b/%b/%b",
                         op, f3, obs_strobes, ctrl.mem_size, ctrl.mem_unsigned, ctrl.illegal,
                         es, sz, un, il);
            end
            @(posedge clk);
            if (il) seen_model = 1'b1;
            #1;
            checks++;
            if (ctrl.illegal_seen !== seen_model) begin
                errors++;
                $display("FAIL rand_seen step %0d: got %b want %b", n, ctrl.illegal_seen, seen_model);
            end
        end
    endtask

    task automatic test_sticky();
        do_reset();
        ctrl.opcode = 7'b0110011; ctrl.funct3 = 3'b000;
        @(posedge clk); #1;
        checks++;
        if (ctrl.illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL sticky_legal: got %b want 0", ctrl.illegal_seen);
        end
        @(negedge clk);
        ctrl.opcode = 7'b0000000;
        @(posedge clk); #1;
        checks++;
        if (ctrl.illegal_seen !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: got %b want 1", ctrl.illegal_seen);
        end
        @(negedge clk);
        ctrl.opcode = 7'b0110011;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ctrl.illegal_seen !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold: got %b want 1", ctrl.illegal_seen);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ctrl.illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want 0", ctrl.illegal_seen);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_model = 1'b0;
    endtask

`ifdef CTRL_ILLEGAL_CNT_EN
    task automatic test_illegal_count();
        int cnt_model;
        do_reset();
        cnt_model = 0;
        ctrl.opcode = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ctrl.illegal_count !== 16'd3) begin
            errors++;
            $display("FAIL count_three: got %0d want 3", ctrl.illegal_count);
        end
        cnt_model = 3;
        while (cnt_model < 65536) begin
            @(posedge clk);
            cnt_model++;
        end
        #1;
        checks++;
        if (ctrl.illegal_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_saturate: got %h want ffff", ctrl.illegal_count);
        end
        @(negedge clk);
        ctrl.opcode = 7'b0110011;
        do_reset();
        #1;
        checks++;
        if (ctrl.illegal_count !== 16'd0) begin
            errors++;
            $display("FAIL count_reset: got %h want 0", ctrl.illegal_count);
        end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        seen_model = 1'b0;
        test_reset();
        test_opcode_table();
        test_unknown_opcodes();
        test_mem_qualifiers();
        test_funct3_illegal();
        test_sticky();
        test_async_reset();
        test_random();
`ifdef CTRL_ILLEGAL_CNT_EN
        test_illegal_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
